// File: rtl/lsu_mem_access_pkg.sv
// Shared constants for the load/store unit memory-access block:
// op_PMEM size codes, load extension codes and FSM state encodings.
package lsu_mem_access_pkg;

    localparam logic [7:0] PMEM_BYTE = 8'h01;
    localparam logic [7:0] PMEM_HALF = 8'h03;
    localparam logic [7:0] PMEM_WORD = 8'h0f;

    localparam logic [1:0] SEXT_NONE = 2'b00;
    localparam logic [1:0] SEXT_BYTE = 2'b01;
    localparam logic [1:0] SEXT_HALF = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Half-words need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(
        input logic [7:0] pmem,
        input logic [1:0] off
    );
        return ((pmem == PMEM_HALF) && off[0]) ||
               ((pmem == PMEM_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_access_load_align.sv
// Combinational load alignment: lane shift, size mask, sign/zero extend.
// Ports: word_i (memory word), off_i (byte offset), pmem_i (size),
//        sext_i (extension mode), data_o (aligned, extended result).
module lsu_load_align
    import lsu_mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [7:0]  pmem_i,
    input  logic [1:0]  sext_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [31:0] masked;

    always_comb begin
        shifted = word_i >> {off_i, 3'b000};

        case (pmem_i)
            PMEM_BYTE: masked = {24'h0, shifted[7:0]};
            PMEM_HALF: masked = {16'h0, shifted[15:0]};
            default:   masked = shifted;
        endcase

        // Code 2'b11 falls through to zero-extension.
        case (sext_i)
            SEXT_BYTE: data_o = {{24{masked[7]}}, masked[7:0]};
            SEXT_HALF: data_o = {{16{masked[15]}}, masked[15:0]};
            default:   data_o = masked;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store memory access unit: one access at a time from execute,
// drives a valid/ready memory request, aligns loads, flags misalign/timeout.
// Ports: in_* (execute request), out_*/rdata/err (writeback result),
//        mem_req_* (request bus), mem_resp_* (memory response).
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load,
    input  logic              store,
    input  logic [7:0]        op_PMEM,
    input  logic [1:0]        op_load_sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    // TIMEOUT must be at least 1.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        pmem_q,  pmem_d;
    logic [1:0]        sext_q,  sext_d;
    logic              load_q,  load_d;
    logic              store_q, store_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [DATA_W-1:0] load_data;

    lsu_load_align u_align (
        .word_i (mem_resp_rdata),
        .off_i  (addr_q[1:0]),
        .pmem_i (pmem_q),
        .sext_i (sext_q),
        .data_o (load_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pmem_d  = pmem_q;
        sext_d  = sext_q;
        load_d  = load_q;
        store_d = store_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    pmem_d  = op_PMEM;
                    sext_d  = op_load_sext;
                    load_d  = load;
                    store_d = store;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (!load && !store) begin
                        state_d = ST_DONE;
                    end else if (misaligned(op_PMEM, addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving on the last counted cycle still wins.
                if (mem_resp_valid) begin
                    rdata_d = (load_q && !store_q) ? load_data : '0;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            pmem_q  <= '0;
            sext_q  <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pmem_q  <= pmem_d;
            sext_q  <= sext_d;
            load_q  <= load_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign rdata         = rdata_q;
    assign err           = err_q;

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_wen   = store_q;
    assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_req_wdata = wdata_q << {addr_q[1:0], 3'b000};
    assign mem_req_wmask = store_q ? (pmem_q[3:0] << addr_q[1:0]) : 4'b0000;

endmodule
